// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded control and operand fields
// for the execute stage, with flush (bubble), freeze (hold) and counters.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   flush, freeze       bubble insert (wins) / hold current contents
//   *_In / *_Out        decoded instruction fields, one-cycle latency
//   stall_cnt           saturating count of freeze-hold edges
//   flush_cnt           saturating count of flush edges
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              freeze,
    input  logic              valid_In,
    input  logic              WB_EN_In,
    input  logic              MEM_R_EN_In,
    input  logic              MEM_W_EN_In,
    input  logic              B_In,
    input  logic              S_In,
    input  logic [CMD_W-1:0]  EXE_CMD_In,
    input  logic [DATA_W-1:0] PC_In,
    input  logic [DATA_W-1:0] Val_Rn_In,
    input  logic [DATA_W-1:0] Val_Rm_In,
    input  logic              imm_In,
    input  logic [11:0]       Shift_operand_In,
    input  logic [23:0]       Signed_imm_24_In,
    input  logic [ADDR_W-1:0] Dest_In,
    input  logic [3:0]        SR_In,
    output logic              valid_Out,
    output logic              WB_EN_Out,
    output logic              MEM_R_EN_Out,
    output logic              MEM_W_EN_Out,
    output logic              B_Out,
    output logic              S_Out,
    output logic [CMD_W-1:0]  EXE_CMD_Out,
    output logic [DATA_W-1:0] PC_Out,
    output logic [DATA_W-1:0] Val_Rn_Out,
    output logic [DATA_W-1:0] Val_Rm_Out,
    output logic              imm_Out,
    output logic [11:0]       Shift_operand_Out,
    output logic [23:0]       Signed_imm_24_Out,
    output logic [ADDR_W-1:0] Dest_Out,
    output logic [3:0]        SR_Out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              b;
        logic              s;
        logic [CMD_W-1:0]  exe_cmd;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift_op;
        logic [23:0]       simm24;
        logic [ADDR_W-1:0] dest;
        logic [3:0]        sr;
    } payload_t;

    payload_t         pl_q, pl_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        pl_d    = pl_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (flush) begin
            pl_d = '0;
            if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
        end else if (freeze) begin
            if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
        end else begin
            // Side-effecting controls are qualified by valid so a dead
            // instruction can never write registers, memory or flags.
            pl_d.valid    = valid_In;
            pl_d.wb_en    = WB_EN_In & valid_In;
            pl_d.mem_r_en = MEM_R_EN_In & valid_In;
            pl_d.mem_w_en = MEM_W_EN_In & valid_In;
            pl_d.b        = B_In & valid_In;
            pl_d.s        = S_In & valid_In;
            pl_d.exe_cmd  = EXE_CMD_In;
            pl_d.pc       = PC_In;
            pl_d.val_rn   = Val_Rn_In;
            pl_d.val_rm   = Val_Rm_In;
            pl_d.imm      = imm_In;
            pl_d.shift_op = Shift_operand_In;
            pl_d.simm24   = Signed_imm_24_In;
            pl_d.dest     = Dest_In;
            pl_d.sr       = SR_In;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pl_q    <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pl_q    <= pl_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign valid_Out         = pl_q.valid;
    assign WB_EN_Out         = pl_q.wb_en;
    assign MEM_R_EN_Out      = pl_q.mem_r_en;
    assign MEM_W_EN_Out      = pl_q.mem_w_en;
    assign B_Out             = pl_q.b;
    assign S_Out             = pl_q.s;
    assign EXE_CMD_Out       = pl_q.exe_cmd;
    assign PC_Out            = pl_q.pc;
    assign Val_Rn_Out        = pl_q.val_rn;
    assign Val_Rm_Out        = pl_q.val_rm;
    assign imm_Out           = pl_q.imm;
    assign Shift_operand_Out = pl_q.shift_op;
    assign Signed_imm_24_Out = pl_q.simm24;
    assign Dest_Out          = pl_q.dest;
    assign SR_Out            = pl_q.sr;
    assign stall_cnt         = stall_q;
    assign flush_cnt         = flush_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: default instance plus a
// CNT_W=2 instance sharing inputs to exercise counter saturation.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        v, wb, mr, mw, b, s;
        logic [3:0]  cmd;
        logic [31:0] pc, rn, rm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] si;
        logic [3:0]  dest, sr;
    } pl_t;

    typedef struct {
        logic rst, fl, fz;
        pl_t  d;
    } in_t;

    typedef struct {
        pl_t         pl;
        logic [15:0] sc, fc;
        logic [1:0]  sc2, fc2;
    } exp_t;

    logic CLK = 0;
    logic RST = 0, flush = 0, freeze = 0;
    pl_t  din = '0;

    pl_t         a1, a2;
    logic [15:0] sc1, fc1;
    logic [1:0]  sc2, fc2;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t m;

    always #5 CLK = ~CLK;

    id_ex_pipe_reg dut (
        .CLK(CLK), .RST(RST), .flush(flush), .freeze(freeze),
        .valid_In(din.v), .WB_EN_In(din.wb), .MEM_R_EN_In(din.mr),
        .MEM_W_EN_In(din.mw), .B_In(din.b), .S_In(din.s),
        .EXE_CMD_In(din.cmd), .PC_In(din.pc), .Val_Rn_In(din.rn),
        .Val_Rm_In(din.rm), .imm_In(din.imm),
        .Shift_operand_In(din.sh), .Signed_imm_24_In(din.si),
        .Dest_In(din.dest), .SR_In(din.sr),
        .valid_Out(a1.v), .WB_EN_Out(a1.wb), .MEM_R_EN_Out(a1.mr),
        .MEM_W_EN_Out(a1.mw), .B_Out(a1.b), .S_Out(a1.s),
        .EXE_CMD_Out(a1.cmd), .PC_Out(a1.pc), .Val_Rn_Out(a1.rn),
        .Val_Rm_Out(a1.rm), .imm_Out(a1.imm),
        .Shift_operand_Out(a1.sh), .Signed_imm_24_Out(a1.si),
        .Dest_Out(a1.dest), .SR_Out(a1.sr),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    id_ex_pipe_reg #(.CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .flush(flush), .freeze(freeze),
        .valid_In(din.v), .WB_EN_In(din.wb), .MEM_R_EN_In(din.mr),
        .MEM_W_EN_In(din.mw), .B_In(din.b), .S_In(din.s),
        .EXE_CMD_In(din.cmd), .PC_In(din.pc), .Val_Rn_In(din.rn),
        .Val_Rm_In(din.rm), .imm_In(din.imm),
        .Shift_operand_In(din.sh), .Signed_imm_24_In(din.si),
        .Dest_In(din.dest), .SR_In(din.sr),
        .valid_Out(a2.v), .WB_EN_Out(a2.wb), .MEM_R_EN_Out(a2.mr),
        .MEM_W_EN_Out(a2.mw), .B_Out(a2.b), .S_Out(a2.s),
        .EXE_CMD_Out(a2.cmd), .PC_Out(a2.pc), .Val_Rn_Out(a2.rn),
        .Val_Rm_Out(a2.rm), .imm_Out(a2.imm),
        .Shift_operand_Out(a2.sh), .Signed_imm_24_Out(a2.si),
        .Dest_Out(a2.dest), .SR_Out(a2.sr),
        .stall_cnt(sc2), .flush_cnt(fc2)
    );

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference model: the register as a record of "what the execute
    // stage should see", updated by the documented priority rules.
    task automatic model(in_t x);
        if (x.rst) begin
            m.pl = '0; m.sc = 0; m.fc = 0; m.sc2 = 0; m.fc2 = 0;
        end else if (x.fl) begin
            m.pl = '0;
            if (int'(m.fc) < 65535) m.fc = m.fc + 1;
            if (int'(m.fc2) < 3) m.fc2 = m.fc2 + 1;
        end else if (x.fz) begin
            if (int'(m.sc) < 65535) m.sc = m.sc + 1;
            if (int'(m.sc2) < 3) m.sc2 = m.sc2 + 1;
        end else begin
            m.pl = x.d;
            m.pl.wb = x.d.wb && x.d.v;
            m.pl.mr = x.d.mr && x.d.v;
            m.pl.mw = x.d.mw && x.d.v;
            m.pl.b  = x.d.b && x.d.v;
            m.pl.s  = x.d.s && x.d.v;
        end
    endtask

    task automatic step(in_t x);
        @(negedge CLK);
        RST = x.rst; flush = x.fl; freeze = x.fz; din = x.d;
        model(x);
        q.push_back(m);
    endtask

    function automatic in_t mk(logic r, logic f, logic z, pl_t d);
        in_t x;
        x.rst = r; x.fl = f; x.fz = z; x.d = d;
        return x;
    endfunction

    function automatic pl_t rnd_pl();
        pl_t p;
        p = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return p;
    endfunction

    // Monitor: the register presents a new word after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("payload", 256'(a1), 256'(e.pl));
                chk("payload_w2", 256'(a2), 256'(e.pl));
                chk("stall_cnt", 256'(sc1), 256'(e.sc));
                chk("flush_cnt", 256'(fc1), 256'(e.fc));
                chk("stall_cnt_w2", 256'(sc2), 256'(e.sc2));
                chk("flush_cnt_w2", 256'(fc2), 256'(e.fc2));
            end
        end
    end

    initial begin
        pl_t p;
        in_t x;
        int  n;
        m.pl = '0; m.sc = 0; m.fc = 0; m.sc2 = 0; m.fc2 = 0;

        step(mk(1, 1, 1, rnd_pl()));
        step(mk(1, 0, 0, rnd_pl()));

        p = '0; p.pc = 32'h8; p.rn = 32'hDEADBEEF;
        p.dest = 4'd5; p.wb = 1; p.v = 1;
        step(mk(0, 0, 0, p));
        @(posedge CLK); #2;
        chk("load_pc", 256'(a1.pc), 256'(32'h8));
        chk("load_rn", 256'(a1.rn), 256'(32'hDEADBEEF));
        chk("load_vwb", 256'({a1.v, a1.wb, a1.dest}), 256'(6'h35));

        p = '0; p.wb = 1; p.mw = 1; p.rm = 32'h55;
        step(mk(0, 0, 0, p));
        @(posedge CLK); #2;
        chk("gate", 256'({a1.v, a1.wb, a1.mw, a1.rm}), 256'(35'h55));

        p = rnd_pl(); p.pc = 32'h10;
        step(mk(0, 0, 0, p));
        p.pc = 32'h14;
        for (int i = 0; i < 3; i++) step(mk(0, 0, 1, p));
        @(posedge CLK); #2;
        chk("frz_pc", 256'(a1.pc), 256'(32'h10));
        chk("frz_cnt", 256'(sc1), 256'(16'd3));
        step(mk(0, 0, 0, p));
        @(posedge CLK); #2;
        chk("rel_pc", 256'(a1.pc), 256'(32'h14));

        step(mk(0, 1, 1, rnd_pl()));
        @(posedge CLK); #2;
        chk("flfz_pl", 256'(a1), 256'(0));
        chk("flfz_cnt", 256'({fc1, sc1}), 256'({16'd1, 16'd3}));

        for (int i = 0; i < 5; i++) step(mk(0, 0, 1, rnd_pl()));
        @(posedge CLK); #2;
        chk("sat_w2", 256'(sc2), 256'(2'd3));
        step(mk(1, 0, 1, rnd_pl()));
        @(posedge CLK); #2;
        chk("rst_frz", 256'({a1, sc1, fc1}), 256'(0));

        for (int i = 0; i < 400; i++) begin
            x = mk($urandom_range(99) < 3, $urandom_range(99) < 12,
                   $urandom_range(99) < 30, rnd_pl());
            step(x);
        end

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge CLK);
            n++;
        end
        @(negedge CLK);
        chk("drain", 256'(q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
